imem_fetch_arbiter: RTL and testbench

- Sequences and shares the single-port, byte-wide instruction memory between two requesters:
  - the core's 32-bit instruction fetch;
  - a byte-stream program loader, used at boot or on reload.
- Holds the core while loading. Assembles 4 byte reads into one big-endian word: byte at addr is [31:24].
- Sits between core fetch stage, loader (UART/debug) and the instruction memory array.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_fetch_arbiter_if.sv | 37 +++
 rtl/imem_byte_assembler.sv | 32 +++
 rtl/imem_fetch_arbiter.sv | 142 ++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch/load arbiter.
package imem_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int ADDR_W_DFLT = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        WAIT,
        LOAD
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Bundle of core-fetch, loader and memory-port signals around the arbiter.
// master = arbiter side, slave = core/loader/memory side.
interface imem_fetch_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_ready;
    logic              load_last;
    logic              load_busy;
    logic              core_hold;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_instr, load_ready, load_busy, core_hold,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_instr, load_ready, load_busy, core_hold,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_byte_assembler.sv
// Shifts read bytes into a big-endian word; the final byte is merged straight
// from the memory bus so the word is valid in the same cycle as o_done.
module imem_byte_assembler
    import imem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_shift,
    input  logic        i_last,
    input  logic [7:0]  i_rdata,
    output logic [31:0] o_word,
    output logic        o_done
);
    logic [8*(INSTR_BYTES-1)-1:0] r_sh;
    logic [31:0]                  r_word;
    logic [31:0]                  w_word;

    assign w_word = {r_sh, i_rdata};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh   <= '0;
            r_word <= '0;
        end else begin
            if (i_shift) r_sh   <= {r_sh[8*(INSTR_BYTES-2)-1:0], i_rdata};
            if (i_last)  r_word <= w_word;
        end
    end

    assign o_word = i_last ? w_word : r_word;
    assign o_done = i_last;
endmodule

// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the byte-wide instruction memory between 4-byte core fetches and
// the boot loader. Define IMEM_CHECKSUM_EN to add the load_csum output.
module imem_fetch_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    imem_fetch_arbiter_if.master bus
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [7:0]          load_csum
`endif
);
    if (RD_LAT != 1) begin : g_lat_chk
        $error("imem_fetch_arbiter supports only RD_LAT == 1");
    end

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_pend;
    logic              r_hold;
    logic              w_hs;
    logic              w_rd;
    logic [1:0]        w_k;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused_addr;

    assign w_unused_addr = ^bus.fetch_addr[31:ADDR_W];
    assign w_hs = (r_state == LOAD) && bus.load_valid;
    assign w_rd = (r_state == RD0) || (r_state == RD1) || (r_state == RD2) || (r_state == RD3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_ptr   <= '0;
            r_pend  <= 1'b0;
            r_hold  <= 1'b1;
        end else begin
            r_hold <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.load_start) begin
                        r_state <= LOAD;
                        r_ptr   <= '0;
                        r_hold  <= 1'b1;
                    end else if (bus.fetch_req) begin
                        r_state <= RD0;
                        r_base  <= bus.fetch_addr[ADDR_W-1:0];
                    end
                end
                RD0, RD1, RD2, RD3: begin
                    if (bus.load_start) r_pend <= 1'b1;
                    case (r_state)
                        RD0:     r_state <= RD1;
                        RD1:     r_state <= RD2;
                        RD2:     r_state <= RD3;
                        default: r_state <= WAIT;
                    endcase
                end
                WAIT: begin
                    r_pend <= 1'b0;
                    if (r_pend || bus.load_start) begin
                        r_state <= LOAD;
                        r_ptr   <= '0;
                        r_hold  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOAD: begin
                    r_hold <= 1'b1;
                    // A restart wins over a byte offered in the same cycle.
                    if (bus.load_start) begin
                        r_ptr <= '0;
                    end else if (w_hs) begin
                        if (bus.load_last) begin
                            r_ptr   <= '0;
                            r_state <= IDLE;
                            r_hold  <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_k = 2'd0;
        case (r_state)
            RD1:     w_k = 2'd1;
            RD2:     w_k = 2'd2;
            RD3:     w_k = 2'd3;
            default: w_k = 2'd0;
        endcase
    end

    always_comb begin
        w_addr = '0;
        if (r_state == LOAD) w_addr = r_ptr;
        else if (w_rd)       w_addr = r_base + ADDR_W'(w_k);
    end

    assign bus.fetch_gnt  = (r_state == IDLE) && !bus.load_start && bus.fetch_req;
    assign bus.load_ready = (r_state == LOAD);
    assign bus.load_busy  = (r_state == LOAD);
    assign bus.core_hold  = r_hold;
    assign bus.mem_en     = w_rd || w_hs;
    assign bus.mem_we     = w_hs;
    assign bus.mem_addr   = w_addr;
    assign bus.mem_wdata  = (r_state == LOAD) ? bus.load_data : 8'h00;

    // Byte k of a fetch returns while the FSM is in the following state.
    imem_byte_assembler u_asm (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_shift (r_state == RD1 || r_state == RD2 || r_state == RD3),
        .i_last  (r_state == WAIT),
        .i_rdata (bus.mem_rdata),
        .o_word  (bus.fetch_instr),
        .o_done  (bus.fetch_valid)
    );

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            r_csum <= 8'h00;
        else if (bus.load_start) r_csum <= 8'h00;
        else if (w_hs)           r_csum <= r_csum + bus.load_data;
    end

    assign load_csum = r_csum;
`endif
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: byte-array memory, table of fetch vectors,
// directed corner sequences and randomized fetch/load mix against a shadow image.
module tb_imem_fetch_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic do_preload = 1'b1;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] q [$];
    int n_tot = 0;
    int n_pass = 0;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0] load_csum;
`endif

    imem_fetch_arbiter_if #(.ADDR_W(8)) bus ();

    imem_fetch_arbiter #(.ADDR_W(8), .RD_LAT(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef IMEM_CHECKSUM_EN
        ,
        .load_csum (load_csum)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int j);
        logic [7:0] jj;
        jj = j[7:0];
        case (j)
            0: return 8'h00;
            1: return 8'h62;
            2: return 8'h97;
            3: return 8'h23;
            default: return jj ^ 8'h5A;
        endcase
    endfunction

    // Synchronous byte memory, one cycle read latency.
    always @(posedge clk) begin
        if (do_preload) begin
            for (int j = 0; j < 256; j++) mem[j] <= init_val(j);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_mem(input string nm);
        int bad = 0;
        for (int j = 0; j < 256; j++) if (mem[j] !== ref_mem[j]) bad++;
        chk({nm, "_mem"}, 64'(bad), 64'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input bit full, input string nm);
        logic [7:0] b;
        logic [7:0] ak;
        b = a[7:0];
        bus.fetch_req = 1'b1;
        bus.fetch_addr = a;
        #1 chk({nm, "_gnt"}, 64'(bus.fetch_gnt), 64'd1);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ak = b + 8'(k);
            if (full) chk({nm, "_rd"}, {bus.mem_en, bus.mem_we, bus.fetch_valid, bus.mem_addr},
                          {1'b1, 1'b0, 1'b0, ak});
            @(negedge clk);
        end
        chk({nm, "_valid"}, {bus.fetch_valid, bus.fetch_instr}, {1'b1, exp});
        @(negedge clk);
        if (full) chk({nm, "_hold"}, {bus.fetch_valid, bus.fetch_instr}, {1'b0, exp});
    endtask

    // Streams d[] to address 0.. and checks every handshake and the resulting image.
    task automatic do_load(input logic [7:0] d[$], input bit gap, input bit with_fetch,
                           input bit started, input string nm);
        int sum = 0;
        logic [7:0] ai;
        if (!started) begin
            bus.load_start = 1'b1;
            bus.fetch_req = with_fetch;
            bus.fetch_addr = 32'h0;
            #1 chk({nm, "_nogntstart"}, 64'(bus.fetch_gnt), 64'd0);
            @(negedge clk);
            bus.load_start = 1'b0;
        end
        #1 chk({nm, "_busy"}, {bus.load_busy, bus.core_hold, bus.load_ready}, 3'b111);
        foreach (d[i]) begin
            if (gap) begin
                bus.load_valid = 1'b0;
                #1 chk({nm, "_gap"}, {bus.mem_en, bus.mem_we}, 2'b00);
                @(negedge clk);
            end
            ai = i[7:0];
            bus.load_valid = 1'b1;
            bus.load_data = d[i];
            bus.load_last = (i == d.size() - 1);
            #1 chk({nm, "_wr"}, {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                   {1'b1, 1'b1, ai, d[i]});
            if (with_fetch) chk({nm, "_nognt"}, 64'(bus.fetch_gnt), 64'd0);
            ref_mem[ai] = d[i];
            sum += int'(d[i]);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        bus.load_last = 1'b0;
        bus.fetch_req = 1'b0;
        #1 chk({nm, "_done"}, {bus.load_busy, bus.core_hold, bus.load_ready}, 3'b000);
        chk_mem(nm);
`ifdef IMEM_CHECKSUM_EN
        chk({nm, "_csum"}, 64'(load_csum), 64'(sum[7:0]));
`endif
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       nm;
    } vec_t;
    vec_t tbl [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0000_0004, 32'h1122_3344, "f4"};
        tbl[1] = '{32'h0000_0000, 32'h0073_02B3, "f0"};
        tbl[2] = '{32'h0000_0002, 32'h02B3_1122, "f2_unal"};
        tbl[3] = '{32'h0000_0001, 32'h7302_B311, "f1_unal"};
        tbl[4] = '{32'h0000_00FE, 32'hA4A5_0073, "fFE_wrap"};
        tbl[5] = '{32'h0000_00FF, 32'hA500_7302, "fFF_wrap"};
        tbl[6] = '{32'hABCD_EF06, 32'h3344_5253, "f6_upper"};

        bus.fetch_req = 0; bus.fetch_addr = 0; bus.load_start = 0;
        bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
        for (int j = 0; j < 256; j++) ref_mem[j] = init_val(j);

        repeat (3) @(negedge clk);
        do_preload = 1'b0;
        chk("reset_outs", {bus.fetch_gnt, bus.fetch_valid, bus.load_ready, bus.load_busy, bus.mem_en,
                           bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_hold, bus.fetch_instr},
            {6'b0, 8'h00, 8'h00, 1'b1, 32'h0});
`ifdef IMEM_CHECKSUM_EN
        chk("reset_csum", 64'(load_csum), 64'd0);
`endif
        reset_n = 1'b1;
        #1 chk("hold_after_rel", 64'(bus.core_hold), 64'd1);
        @(negedge clk);
        chk("hold_drop", 64'(bus.core_hold), 64'd0);

        do_fetch(32'h0, 32'h0062_9723, 1'b1, "fetch0");

        q = '{8'h00, 8'h73, 8'h02, 8'hB3, 8'h11, 8'h22, 8'h33, 8'h44};
        do_load(q, 1'b0, 1'b0, 1'b0, "load8");

        for (int i = 0; i < 7; i++) do_fetch(tbl[i].addr, tbl[i].exp, 1'b1, tbl[i].nm);

        q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        do_load(q, 1'b1, 1'b0, 1'b0, "load_gap");
        do_fetch(32'h1, 32'hB2C3_D4E5, 1'b1, "fgap");

        // load_start during RD2 with fetch_req held: fetch finishes, then LOAD.
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 32'h4;
        #1 chk("rd2_gnt", 64'(bus.fetch_gnt), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rd2_nogntrd", 64'(bus.fetch_gnt), 64'd0);
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        @(negedge clk);
        chk("rd2_valid", {bus.fetch_valid, bus.fetch_instr}, {1'b1, 32'hE522_3344});
        @(negedge clk);
        q = '{8'h5A, 8'h6B};
        do_load(q, 1'b0, 1'b1, 1'b1, "rd2_load");

        // Reset in the middle of a load.
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        q = '{8'h01, 8'hFF, 8'h02};
        foreach (q[i]) begin
            bus.load_valid = 1'b1;
            bus.load_data = q[i];
            ref_mem[i] = q[i];
            @(negedge clk);
        end
        bus.load_data = 8'h77;
`ifdef IMEM_CHECKSUM_EN
        #1 chk("mid_csum", 64'(load_csum), 64'h02);
`endif
        reset_n = 1'b0;
        #1 chk("mid_rst", {bus.mem_en, bus.mem_we, bus.load_busy, bus.core_hold}, 4'b0001);
        @(negedge clk);
        bus.load_valid = 1'b0;
        reset_n = 1'b1;
        #1 chk("mid_rel_hold", 64'(bus.core_hold), 64'd1);
`ifdef IMEM_CHECKSUM_EN
        chk("mid_rst_csum", 64'(load_csum), 64'd0);
`endif
        @(negedge clk);
        chk("mid_hold_drop", 64'(bus.core_hold), 64'd0);
        chk_mem("mid_partial");
        q = '{8'hC0, 8'hC1};
        do_load(q, 1'b0, 1'b0, 1'b0, "reload");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                logic [31:0] a;
                a = $urandom;
                do_fetch(a, ref_word(a[7:0]), 1'b0, "rnd_fetch");
            end else begin
                int len;
                len = $urandom_range(1, 10);
                q.delete();
                for (int j = 0; j < len; j++) q.push_back(8'($urandom));
                do_load(q, 1'($urandom), 1'($urandom), 1'b0, "rnd_load");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
